// File: rtl/ysyx_23060208_lsu.sv
// Load/store unit: one EXU request at a time over valid/ready, mapped onto an
// AXI4-Lite master with byte-lane steering, load extension, error and timeout reporting.
module ysyx_23060208_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic [STRB_WIDTH-1:0] axi_wstrb,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);

  localparam int unsigned OFF_W = $clog2(STRB_WIDTH);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TO_EN = (TIMEOUT != 0);

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_MISAL = 2'd1;
  localparam logic [1:0] ERR_BUS   = 2'd2;
  localparam logic [1:0] ERR_TO    = 2'd3;

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            err_q, err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  resp_valid_q, resp_valid_d;

  logic                  misal_c;
  logic [STRB_WIDTH-1:0] strb_mask_c;
  logic [DATA_WIDTH-1:0] lane_c, lmask_c, ext_c;
  logic                  sbit_c;
  logic [CNT_W-1:0]      cnt_inc_c;
  logic                  to_hit_c;

  // Request decode: alignment check and unshifted strobe mask
  always_comb begin
    misal_c     = 1'b0;
    strb_mask_c = STRB_WIDTH'(8'h01);
    case (req_size)
      2'd0: begin misal_c = 1'b0;                strb_mask_c = STRB_WIDTH'(8'h01); end
      2'd1: begin misal_c = req_addr[0];         strb_mask_c = STRB_WIDTH'(8'h03); end
      2'd2: begin misal_c = |req_addr[1:0];      strb_mask_c = STRB_WIDTH'(8'h0F); end
      default: begin
        misal_c     = (DATA_WIDTH == 32) || (|req_addr[2:0]);
        strb_mask_c = STRB_WIDTH'(8'hFF);
      end
    endcase
  end

  // Load lane select, truncation and sign/zero extension
  always_comb begin
    lane_c  = axi_rdata >> {addr_q[OFF_W-1:0], 3'b000};
    lmask_c = '1;
    sbit_c  = lane_c[DATA_WIDTH-1];
    case (size_q)
      2'd0: begin lmask_c = DATA_WIDTH'(64'hFF);        sbit_c = lane_c[7];  end
      2'd1: begin lmask_c = DATA_WIDTH'(64'hFFFF);      sbit_c = lane_c[15]; end
      2'd2: begin lmask_c = DATA_WIDTH'(64'hFFFF_FFFF); sbit_c = lane_c[31]; end
      default: begin lmask_c = '1; sbit_c = lane_c[DATA_WIDTH-1]; end
    endcase
    ext_c = (sgn_q && sbit_c) ? ((lane_c & lmask_c) | ~lmask_c) : (lane_c & lmask_c);
  end

  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign to_hit_c  = TO_EN && (cnt_inc_c == CNT_W'(TIMEOUT));

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          size_d    = req_size;
          sgn_d     = req_signed;
          wdata_d   = req_wdata << {req_addr[OFF_W-1:0], 3'b000};
          wstrb_d   = strb_mask_c << req_addr[OFF_W-1:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          err_d     = ERR_OK;
          if (misal_c) begin
            state_d = RESP;
            err_d   = ERR_MISAL;
          end else begin
            state_d = req_wen ? WR_AW : RD_A;
          end
        end
      end
      RD_A: begin
        cnt_d = cnt_inc_c;
        if (arvalid_q && axi_arready) begin
          state_d = RD_D;
        end else if (to_hit_c) begin
          state_d = RESP;
          err_d   = ERR_TO;
        end
      end
      RD_D: begin
        cnt_d = cnt_inc_c;
        if (rready_q && axi_rvalid) begin
          state_d = RESP;
          if (axi_rresp != 2'b00) begin
            rdata_d = '0;
            err_d   = ERR_BUS;
          end else begin
            rdata_d = ext_c;
          end
        end else if (to_hit_c) begin
          state_d = RESP;
          err_d   = ERR_TO;
        end
      end
      WR_AW: begin
        cnt_d     = cnt_inc_c;
        aw_done_d = aw_done_q | (awvalid_q & axi_awready);
        w_done_d  = w_done_q | (wvalid_q & axi_wready);
        if (aw_done_d && w_done_d) begin
          state_d = WR_B;
        end else if (to_hit_c) begin
          state_d = RESP;
          err_d   = ERR_TO;
        end
      end
      WR_B: begin
        cnt_d = cnt_inc_c;
        if (bready_q && axi_bvalid) begin
          state_d = RESP;
          err_d   = (axi_bresp != 2'b00) ? ERR_BUS : ERR_OK;
        end else if (to_hit_c) begin
          state_d = RESP;
          err_d   = ERR_TO;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;

    req_ready_d  = (state_d == IDLE);
    arvalid_d    = (state_d == RD_A);
    rready_d     = (state_d == RD_D);
    awvalid_d    = (state_d == WR_AW) && !aw_done_d;
    wvalid_d     = (state_d == WR_AW) && !w_done_d;
    bready_d     = (state_d == WR_B);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      sgn_q        <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= ERR_OK;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign axi_araddr  = {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
  assign axi_awaddr  = {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;

endmodule

// File: doc/ysyx_23060208_lsu.md
Name: ysyx_23060208_lsu

Overview:
Parametrised load/store unit between the EXU and the data-side AXI4-Lite bus. It replaces the EXU-internal read and write handshake FSMs with one standalone block. It adds configurable data width, true per-byte write strobes with lane steering, sign or zero extension, misalignment detection, error-response reporting and a bus timeout. The EXU issues one request at a time through a valid/ready port and waits on a valid/ready response port before retiring the instruction.

Parameters:
ADDR_WIDTH, 32, address width of the request and the AXI channels
DATA_WIDTH, 32, bus/register data width; legal values 32 or 64
TIMEOUT, 255, cycles to wait for any single AXI handshake before aborting; 0 disables the timeout
STRB_WIDTH, DATA_WIDTH/8, derived; do not override

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  EXU request valid
req_ready  out  1  LSU can accept a request
req_wen  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword only when DATA_WIDTH=64)
req_signed  in  1  load sign-extends when 1
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
resp_valid  out  1  response valid
resp_ready  in  1  EXU accepts the response
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores
resp_err  out  2  0 = ok, 1 = misaligned, 2 = bus error (SLVERR/DECERR), 3 = timeout
axi_awaddr/awvalid/awready, axi_wdata/wstrb/wvalid/wready, axi_bresp/bvalid/bready, axi_araddr/arvalid/arready, axi_rdata/rresp/rvalid/rready  AXI4-Lite master signals; widths per ADDR_WIDTH, DATA_WIDTH and STRB_WIDTH; resp signals are 2 bits wide

Behaviour:
- Reset: the asynchronous assertion of rst forces state IDLE immediately. All valid and ready outputs except req_ready go to 0 at once. resp_rdata, resp_err and the timeout counter go to 0. req_ready goes to 1.
- Reset mid-transaction abandons the transaction with no response. The slave is reset by the same rst.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP.
- IDLE: req_ready=1. On req_valid the LSU latches all req_* fields and checks alignment.
  - Misaligned means addr[size-1:0] != 0; size=3 is also illegal when DATA_WIDTH=32.
  - Misaligned or illegal request: go to RESP with err=1. No bus activity.
  - Aligned load: go to RD_A. Aligned store: go to WR_AW.
- All AXI outputs are registered. The first valid appears the cycle after acceptance.
- RD_A: arvalid=1, araddr = latched address with the low log2(STRB_WIDTH) bits cleared. On arready, go to RD_D.
- RD_D: rready=1. On rvalid, capture rdata.
  - Select the lane at addr[log2(STRB_WIDTH)-1:0] bytes, truncate to size, then sign- or zero-extend.
  - rresp != 0: err=2 and rdata forced to 0. Then go to RESP.
- WR_AW: awvalid and wvalid are asserted together and handshake independently.
  - Per-channel done flags drop each valid after its own handshake; both may complete in the same cycle.
  - wdata = req_wdata shifted left by 8×offset.
  - wstrb = (2^(2^size)-1) << offset. Example: sh to 0x...2 at 32 bits gives wstrb=4'b1100.
  - When both flags are set, go to WR_B.
- WR_B: bready=1. On bvalid go to RESP; bresp != 0 gives err=2.
- Timeout counter: cleared on every state entry and incremented each cycle spent in RD_A, RD_D, WR_AW or WR_B.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT, drop all AXI valids and readies and go to RESP with err=3.
  - The abort is not reported on the bus.
- RESP: resp_valid=1 and the outputs are held stable until resp_ready. On handshake go to IDLE. req_ready is 0 in RESP.
- Latency with a zero-wait slave: load is request accept → ar (cycle 1) → r (cycle 2) → resp_valid (cycle 3). Store has the same latency.
- An error response after misalignment arrives on cycle 1.
- Exactly one transaction is outstanding at a time. No new request is accepted until the response handshake completes.

Test Plan:
- lw 0x80000004, slave returns 0xDEADBEEF with rresp=0, zero-wait → araddr=0x80000004; resp_rdata=0xDEADBEEF, err=0, resp_valid on cycle 3.
- lb signed at 0x80000003, rdata=0x80112233 → resp_rdata=0xFFFFFF80. The same access with lbu → 0x00000080.
- sh 0x0000ABCD to 0x80000002 → wdata=0xABCD0000, wstrb=4'b1100. Slave raises awready 3 cycles before wready; each valid drops separately after its own handshake; resp err=0.
- lw to 0x80000001 → resp_err=1 on cycle 1; arvalid and awvalid never assert.
- Store with bresp=2'b10 → err=2. With TIMEOUT=4 and arready held 0 → arvalid drops after 4 cycles and resp_err=3.
- Assert rst while in RD_D → arvalid and rready are 0 immediately, req_ready=1, and no resp_valid follows.
